mem_arbiter: RTL and testbench

- Shares one single-port unified memory between instruction fetch (IF stage) and data access (MEM stage) of the RV32I pipeline.
- Sequences each access as a request/grant/acknowledge transaction and returns read data to the owning requester.
- Drives the stall signals that freeze the pipeline while an access is outstanding.
- Data access has priority; an anti-starvation counter guarantees fetch progress. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant, and a watchdog aborts unacknowledged accesses.
module mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_DM_STREAK = 4,
   parameter int TIMEOUT       = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   input  logic                dm_rd,
   input  logic                dm_wr,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                err
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(MAX_DM_STREAK + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   logic [SW-1:0]       r_streak;
   logic [7:0]          r_tcnt;
   logic                r_owner_dm;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [BE_W-1:0]     r_mem_be;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_dm_rdata;
   logic                r_if_ready;
   logic                r_dm_ready;
   logic                r_err;

   logic w_dm_req;
   logic w_force_if;
   logic w_grant_if;
   logic w_grant_dm;
   logic w_dm_write;
   logic w_timeout;

   assign w_dm_req   = dm_rd | dm_wr;
   assign w_force_if = if_req & (r_streak == SW'(MAX_DM_STREAK));
   assign w_grant_if = if_req & (~w_dm_req | w_force_if);
   assign w_grant_dm = w_dm_req & ~w_grant_if;
   // rd+wr together is a store
   assign w_dm_write = w_grant_dm & dm_wr;
   assign w_timeout  = (r_tcnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_streak    <= '0;
         r_tcnt      <= '0;
         r_owner_dm  <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_ready  <= 1'b0;
         r_dm_ready  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_en   <= 1'b0;
         r_if_ready <= 1'b0;
         r_dm_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_if || w_grant_dm) begin
                  r_state     <= S_ISSUE;
                  r_mem_en    <= 1'b1;
                  r_owner_dm  <= w_grant_dm;
                  r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
                  r_mem_we    <= w_dm_write;
                  r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
                  r_mem_be    <= w_dm_write ? dm_be : '1;
                  if (w_grant_if)
                     r_streak <= '0;
                  else if (if_req)
                     r_streak <= r_streak + 1'b1;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               r_tcnt <= r_tcnt + 1'b1;
               if (mem_ack || w_timeout) begin
                  r_state    <= S_RESP;
                  r_if_ready <= ~r_owner_dm;
                  r_dm_ready <= r_owner_dm;
                  if (!mem_ack)
                     r_err <= 1'b1;
                  // Abort returns zero; an acknowledged store leaves load data untouched
                  if (!r_owner_dm)
                     r_if_rdata <= mem_ack ? mem_rdata : '0;
                  else if (!mem_ack)
                     r_dm_rdata <= '0;
                  else if (!r_mem_we)
                     r_dm_rdata <= mem_rdata;
               end
            end
            S_RESP: begin
               // No grant here: the pipeline still holds the old request on this edge
               r_tcnt  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign if_rdata  = r_if_rdata;
   assign dm_rdata  = r_dm_rdata;
   assign if_ready  = r_if_ready;
   assign dm_ready  = r_dm_ready;
   assign err       = r_err;
   assign stall_if  = if_req & ~r_if_ready;
   assign stall_mem = w_dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands/responses queued at stimulus time,
// popped and compared when mem_en or a ready pulse is seen.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_rd = 1'b0;
   logic        dm_wr = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [3:0]  dm_be = '0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        err;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} cmd_t;
   typedef struct packed {logic is_dm; logic [31:0] rdata;} rsp_t;

   cmd_t exp_cmd_q[$];
   rsp_t exp_rsp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic no_ack = 1'b0;
   logic [31:0] exp_dm_rdata = '0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
   endfunction

   // Memory model: acknowledges one cycle after mem_en; stores return junk on rdata
   int          pend = 0;
   logic [31:0] rd_val = '0;
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (!rst_n) begin
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = rd_val;
            end
         end
         if (mem_en && !no_ack) begin
            pend   = 1;
            rd_val = mem_we ? 32'hBAD0_BAD0 : mem_val(mem_addr);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({mem_en, mem_we, if_ready, dm_ready, err, stall_if, stall_mem} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl got %b want 0000000", {mem_en, mem_we, if_ready, dm_ready, err, stall_if, stall_mem});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
         n_err++;
         $display("FAIL reset_mem got addr=%h wdata=%h be=%b want 0", mem_addr, mem_wdata, mem_be);
      end
      n_vec++;
      if ({if_rdata, dm_rdata} !== 64'h0) begin
         n_err++;
         $display("FAIL reset_rdata got if=%h dm=%h want 0", if_rdata, dm_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      cmd_t e;
      rsp_t r;
      exp_cmd_q.push_back({1'b0, 32'h100, 32'h0, 4'hF});
      exp_rsp_q.push_back({1'b0, 32'h0050_0093});
      if_addr = 32'h100;
      if_req  = 1'b1;
      #1;
      n_vec++;
      if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_t got %b want 1", stall_if); end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1 || c == 2) begin
            n_vec++;
            if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall c=%0d got %b want 1", c, stall_if); end
         end
         if (mem_en) begin
            n_vec++;
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL fetch_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (c != 1 || mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be) begin
                  n_err++;
                  $display("FAIL fetch_cmd c=%0d got we=%b addr=%h be=%b want c=1 we=%b addr=%h be=%b",
                           c, mem_we, mem_addr, mem_be, e.we, e.addr, e.be);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL fetch_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (c != 3 || dm_ready !== r.is_dm || if_ready === r.is_dm || if_rdata !== r.rdata || stall_if !== 1'b0) begin
                  n_err++;
                  $display("FAIL fetch_rsp c=%0d got ifr=%b dmr=%b rdata=%h stall=%b want c=3 ifr=1 rdata=%h stall=0",
                           c, if_ready, dm_ready, if_rdata, stall_if, r.rdata);
               end
            end
            if_req = 1'b0;
         end
      end
      n_vec++;
      if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_err++; $display("FAIL fetch_missing cmd=%0d rsp=%0d want 0 0", exp_cmd_q.size(), exp_rsp_q.size());
      end
      exp_cmd_q.delete(); exp_rsp_q.delete(); if_req = 1'b0;
   endtask

   task automatic test_priority();
      cmd_t e;
      rsp_t r;
      int   en_cyc[$];
      exp_cmd_q.push_back({1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
      exp_cmd_q.push_back({1'b0, 32'h104, 32'h0, 4'hF});
      exp_rsp_q.push_back({1'b1, exp_dm_rdata});
      exp_rsp_q.push_back({1'b0, mem_val(32'h104)});
      if_addr = 32'h104; if_req = 1'b1;
      dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011; dm_wr = 1'b1;
      #1;
      n_vec++;
      if (stall_mem !== 1'b1) begin n_err++; $display("FAIL prio_stall_mem got %b want 1", stall_mem); end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_en) begin
            n_vec++;
            en_cyc.push_back(c);
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL prio_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be || (e.we && mem_wdata !== e.wdata)) begin
                  n_err++;
                  $display("FAIL prio_cmd c=%0d got we=%b addr=%h wd=%h be=%b want we=%b addr=%h wd=%h be=%b",
                           c, mem_we, mem_addr, mem_wdata, mem_be, e.we, e.addr, e.wdata, e.be);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL prio_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (dm_ready !== r.is_dm || if_ready === r.is_dm || (r.is_dm ? dm_rdata : if_rdata) !== r.rdata) begin
                  n_err++;
                  $display("FAIL prio_rsp c=%0d got ifr=%b dmr=%b ifd=%h dmd=%h want dm=%b rdata=%h",
                           c, if_ready, dm_ready, if_rdata, dm_rdata, r.is_dm, r.rdata);
               end
            end
            if (dm_ready) dm_wr = 1'b0;
            if (if_ready) if_req = 1'b0;
         end
      end
      n_vec++;
      if (en_cyc.size() != 2 || en_cyc[1] - en_cyc[0] != 4) begin
         n_err++; $display("FAIL prio_spacing got n=%0d want 2 grants 4 cycles apart", en_cyc.size());
      end
      n_vec++;
      if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_err++; $display("FAIL prio_missing cmd=%0d rsp=%0d want 0 0", exp_cmd_q.size(), exp_rsp_q.size());
      end
      exp_cmd_q.delete(); exp_rsp_q.delete(); if_req = 1'b0; dm_wr = 1'b0;
   endtask

   task automatic test_streak();
      cmd_t e;
      rsp_t r;
      int   ncmd = 0;
      string order = "DDDDIDDDDI";
      for (int k = 0; k < 10; k++) begin
         if (order[k] == "D") begin
            exp_cmd_q.push_back({1'b0, 32'h3000, 32'h0, 4'hF});
            exp_rsp_q.push_back({1'b1, mem_val(32'h3000)});
         end else begin
            exp_cmd_q.push_back({1'b0, 32'h104, 32'h0, 4'hF});
            exp_rsp_q.push_back({1'b0, mem_val(32'h104)});
         end
      end
      if_addr = 32'h104; if_req = 1'b1;
      dm_addr = 32'h3000; dm_be = 4'b0101; dm_rd = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (mem_en) begin
            n_vec++;
            ncmd++;
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL streak_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be) begin
                  n_err++;
                  $display("FAIL streak_cmd #%0d got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                           ncmd, mem_we, mem_addr, mem_be, e.we, e.addr, e.be);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL streak_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (dm_ready !== r.is_dm || if_ready === r.is_dm || (r.is_dm ? dm_rdata : if_rdata) !== r.rdata) begin
                  n_err++;
                  $display("FAIL streak_rsp c=%0d got ifr=%b dmr=%b ifd=%h dmd=%h want dm=%b rdata=%h",
                           c, if_ready, dm_ready, if_rdata, dm_rdata, r.is_dm, r.rdata);
               end
            end
            if (ncmd >= 10) begin if_req = 1'b0; dm_rd = 1'b0; end
         end
      end
      n_vec++;
      if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_err++; $display("FAIL streak_missing cmd=%0d rsp=%0d want 0 0", exp_cmd_q.size(), exp_rsp_q.size());
      end
      exp_cmd_q.delete(); exp_rsp_q.delete(); if_req = 1'b0; dm_rd = 1'b0;
      exp_dm_rdata = mem_val(32'h3000);
   endtask

   task automatic test_rdwr();
      cmd_t e;
      rsp_t r;
      exp_cmd_q.push_back({1'b1, 32'h40, 32'h1234_5678, 4'b1100});
      exp_rsp_q.push_back({1'b1, exp_dm_rdata});
      dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_be = 4'b1100;
      dm_rd = 1'b1; dm_wr = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_en) begin
            n_vec++;
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL rdwr_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be || mem_wdata !== e.wdata) begin
                  n_err++;
                  $display("FAIL rdwr_cmd got we=%b addr=%h wd=%h be=%b want we=%b addr=%h wd=%h be=%b",
                           mem_we, mem_addr, mem_wdata, mem_be, e.we, e.addr, e.wdata, e.be);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL rdwr_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== r.rdata) begin
                  n_err++;
                  $display("FAIL rdwr_rsp got dmr=%b ifr=%b dm_rdata=%h want dmr=1 ifr=0 dm_rdata=%h",
                           dm_ready, if_ready, dm_rdata, r.rdata);
               end
            end
            dm_rd = 1'b0; dm_wr = 1'b0;
         end
      end
      n_vec++;
      if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_err++; $display("FAIL rdwr_missing cmd=%0d rsp=%0d want 0 0", exp_cmd_q.size(), exp_rsp_q.size());
      end
      exp_cmd_q.delete(); exp_rsp_q.delete(); dm_rd = 1'b0; dm_wr = 1'b0;
   endtask

   task automatic test_timeout();
      cmd_t e;
      rsp_t r;
      no_ack = 1'b1;
      exp_cmd_q.push_back({1'b0, 32'h80, 32'h0, 4'hF});
      exp_rsp_q.push_back({1'b1, 32'h0});
      dm_addr = 32'h80; dm_be = 4'b0001; dm_rd = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c == 16) begin
            n_vec++;
            if (err !== 1'b0) begin n_err++; $display("FAIL tmo_err_early got %b want 0", err); end
         end
         if (mem_en) begin
            n_vec++;
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL tmo_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || mem_be !== e.be) begin
                  n_err++;
                  $display("FAIL tmo_cmd got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                           mem_we, mem_addr, mem_be, e.we, e.addr, e.be);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL tmo_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (c != 17 || dm_ready !== 1'b1 || dm_rdata !== r.rdata || err !== 1'b1) begin
                  n_err++;
                  $display("FAIL tmo_rsp c=%0d got dmr=%b dm_rdata=%h err=%b want c=17 dmr=1 dm_rdata=%h err=1",
                           c, dm_ready, dm_rdata, err, r.rdata);
               end
            end
            dm_rd = 1'b0;
         end
      end
      no_ack = 1'b0;
      exp_dm_rdata = 32'h0;
      // A later good access keeps the sticky flag
      exp_cmd_q.push_back({1'b0, 32'h100, 32'h0, 4'hF});
      exp_rsp_q.push_back({1'b0, 32'h0050_0093});
      if_addr = 32'h100; if_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_en) begin
            n_vec++;
            if (exp_cmd_q.size() == 0) begin n_err++; $display("FAIL tmo2_extra_cmd c=%0d addr=%h", c, mem_addr); end
            else begin
               e = exp_cmd_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr) begin
                  n_err++; $display("FAIL tmo2_cmd got we=%b addr=%h want we=%b addr=%h", mem_we, mem_addr, e.we, e.addr);
               end
            end
         end
         if (if_ready || dm_ready) begin
            n_vec++;
            if (exp_rsp_q.size() == 0) begin n_err++; $display("FAIL tmo2_extra_rdy c=%0d", c); end
            else begin
               r = exp_rsp_q.pop_front();
               if (if_ready !== 1'b1 || if_rdata !== r.rdata || err !== 1'b1) begin
                  n_err++;
                  $display("FAIL tmo2_rsp got ifr=%b if_rdata=%h err=%b want ifr=1 if_rdata=%h err=1",
                           if_ready, if_rdata, err, r.rdata);
               end
            end
            if_req = 1'b0;
         end
      end
      n_vec++;
      if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_err++; $display("FAIL tmo_missing cmd=%0d rsp=%0d want 0 0", exp_cmd_q.size(), exp_rsp_q.size());
      end
      exp_cmd_q.delete(); exp_rsp_q.delete(); if_req = 1'b0; dm_rd = 1'b0;
   endtask

   task automatic test_reset_mid();
      no_ack = 1'b1;
      if_addr = 32'h200; if_req = 1'b1;
      @(negedge clk);
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
         n_err++; $display("FAIL rstmid_issue got en=%b addr=%h want en=1 addr=00000200", mem_en, mem_addr);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({mem_en, mem_we, err, if_ready, dm_ready} !== 5'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 ||
          if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rstmid_clear got en=%b err=%b addr=%h be=%b ifd=%h dmd=%h want all 0",
                  mem_en, err, mem_addr, mem_be, if_rdata, dm_rdata);
      end
      if_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      no_ack = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_vec++;
         if (mem_en !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet c=%0d got en=%b ifr=%b dmr=%b want 0 0 0", c, mem_en, if_ready, dm_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_streak();
      test_rdwr();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
